piso_tx_arbiter: RTL and testbench
==================================

Name: piso_tx_arbiter

Overview:
- Round-robin controller that shares one WIDTH-bit parallel-in/serial-out shift stage between two word requesters.
- Accepts a word from one requester via a valid/ready handshake, loads it, and shifts it out LSB first, one bit per clock.
- Frames the serial stream with so_valid, so_last and so_src.
- Sits between the register-file/producer side and the single-wire serial link.

Parameters:
- WIDTH, 4, word width and number of serial bits per word (>=2).
- GAP, 0, extra idle cycles inserted after each word, on top of the mandatory single IDLE cycle.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req0_valid  input  1  requester 0 has a word
- req0_data  input  WIDTH  requester 0 word
- req0_ready  output  1  requester 0 word accepted this cycle
- req1_valid  input  1  requester 1 has a word
- req1_data  input  WIDTH  requester 1 word
- req1_ready  output  1  requester 1 word accepted this cycle
- so  output  1  serial data, LSB first
- so_valid  output  1  so carries a data bit
- so_last  output  1  final bit of the current word
- so_src  output  1  source of the word being shifted (0/1)
- busy  output  1  high in SHIFT and GAP

Behaviour:
- Reset (async, any state, including mid-word):
  - state=IDLE; shift reg, bit counter and gap counter = 0; priority pointer = req0.
  - Outputs so=0, so_valid=0, so_last=0, so_src=0, busy=0, req0_ready=0, req1_ready=0.
  - A partially shifted word is discarded and never resumed.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Grant is combinational from the valid inputs and the pointer.
  - One valid: that requester's ready=1.
  - Both valid: ready goes to the requester named by the pointer.
  - Never both readies high.
  - Handshake = valid & ready at a rising edge: data loads into the shift reg, so_src registers the granted id, bit counter=0, pointer moves to the other requester, next state SHIFT.
  - No valid: stay in IDLE, pointer unchanged.
- SHIFT:
  - so=shift_reg[0], so_valid=1, busy=1, readies=0.
  - Each edge: shift reg >>1 with zero fill; counter+1.
  - so_last=1 when counter==WIDTH-1.
  - After the last-bit cycle: next state is GAP if GAP>0, else IDLE.
- GAP:
  - so_valid=0, so=0, busy=1, readies=0.
  - Holds for exactly GAP cycles, then goes to IDLE.
- Latency:
  - Handshake at edge T: bit0 on so during cycle T..T+1, bit WIDTH-1 on the WIDTH-th cycle.
  - Minimum spacing between handshakes is WIDTH+1+GAP cycles.
- Fairness:
  - With both requesters continuously valid, grants alternate 0,1,0,1.
  - A lone requester is granted every opportunity; the pointer does not block it.
- Requester rules: data must be held stable while valid=1 and ready=0; valid must not drop before the handshake.
- so, so_valid and so_last are driven from registered state only; no combinational path from the inputs.

Test Plan:
1. Reset, then req0_valid=1 with data 4'b1101 for one handshake -> so=1,0,1,1 over 4 cycles; so_valid=1 throughout; so_last only on the 4th cycle; so_src=0; busy=1 for those 4 cycles.
2. From reset, req0 and req1 both valid, data 4'b0011 and 4'b1010 -> req0 granted first (bits 1,1,0,0), then req1 (bits 0,1,0,1) with so_src=1. Continued with both valid -> grant order 0,1,0,1.
3. Only req1 continuously valid, GAP=0 -> consecutive req1 handshakes exactly 5 cycles apart; readies never high in SHIFT.
4. GAP=2, WIDTH=8, single word 8'hA5 -> 8 bits 1,0,1,0,0,1,0,1; then 2 cycles with busy=1 and so_valid=0; next ready no earlier than the following IDLE cycle.
5. Assert rst for one cycle after the 2nd bit of 4'b1111 -> so_valid, busy and so drop to 0 immediately (async). After release: IDLE; a pending req1 and req0 pair -> req0 granted (pointer reset).
6. req0_valid rises at the same edge a word finishes its last bit -> no ready during the SHIFT cycles; ready asserted in the following IDLE cycle.

Source files
------------

// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter feeding one WIDTH-bit parallel-in/serial-out shifter.
// Words are shifted LSB first, framed by so_valid/so_last/so_src.
module piso_tx_arbiter #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_last,
  output logic             so_src,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             ptr_q, ptr_d;
  logic             src_q, src_d;
  logic             grant0, grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      gap_cnt_q <= '0;
      ptr_q     <= 1'b0;
      src_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ptr_q     <= ptr_d;
      src_q     <= src_d;
    end
  end

  // The pointer only breaks ties; a lone requester always wins.
  assign grant0 = req0_valid & (~req1_valid | ~ptr_q);
  assign grant1 = req1_valid & (~req0_valid | ptr_q);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ptr_d      = ptr_q;
    src_d      = src_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req0_ready = grant0 & ~rst;
        req1_ready = grant1 & ~rst;
        if (grant0 | grant1) begin
          shift_d = grant1 ? req1_data : req0_data;
          src_d   = grant1;
          ptr_d   = ~grant1;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          gap_cnt_d = '0;
          state_d   = (GAP > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign so       = (state_q == S_SHIFT) & shift_q[0];
  assign so_valid = (state_q == S_SHIFT);
  assign so_last  = (state_q == S_SHIFT) & (cnt_q == CNT_LAST);
  assign so_src   = src_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed self-checking bench: a WIDTH=4/GAP=0 instance and a WIDTH=8/GAP=2 instance.
module tb_piso_tx_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       so, so_valid, so_last, so_src, busy;

  logic       w_valid, w1_valid;
  logic [7:0] w_data, w1_data;
  logic       w_ready, w1_ready;
  logic       w_so, w_so_valid, w_so_last, w_so_src, w_busy;

  int errors = 0;
  int checks = 0;

  piso_tx_arbiter #(.WIDTH(4), .GAP(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .so(so), .so_valid(so_valid), .so_last(so_last), .so_src(so_src), .busy(busy)
  );

  piso_tx_arbiter #(.WIDTH(8), .GAP(2)) dut8 (
    .clk(clk), .rst(rst),
    .req0_valid(w_valid), .req0_data(w_data), .req0_ready(w_ready),
    .req1_valid(w1_valid), .req1_data(w1_data), .req1_ready(w1_ready),
    .so(w_so), .so_valid(w_so_valid), .so_last(w_so_last), .so_src(w_so_src), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] d0,
                               input logic v1, input logic [3:0] d1);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Called in the first SHIFT cycle; returns in the cycle after the last bit.
  task automatic expectWord(input logic [3:0] data, input logic src);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("so[%0d]", i), 32'(so), 32'(data[i]));
      checkOutput("so_valid", 32'(so_valid), 32'(1));
      checkOutput("so_last", 32'(so_last), 32'(i == 3));
      checkOutput("so_src", 32'(so_src), 32'(src));
      checkOutput("busy", 32'(busy), 32'(1));
      checkOutput("ready_in_shift", 32'({req1_ready, req0_ready}), 32'(0));
      step();
    end
  endtask

  initial begin
    int hs[8];
    int n;
    int viol;
    logic [7:0] a5;

    rst = 1'b1;
    w_valid = 1'b0; w_data = 8'h00; w1_valid = 1'b0; w1_data = 8'h00;
    applyStimulus(1'b1, 4'b0101, 1'b1, 4'b0101);
    step();
    checkOutput("rst_readies", 32'({req1_ready, req0_ready}), 32'(0));
    checkOutput("rst_outputs", 32'({so, so_valid, so_last, so_src, busy}), 32'(0));
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0);
    applyReset();

    // Single req0 word
    applyStimulus(1'b1, 4'b1101, 1'b0, 4'b0);
    checkOutput("t1_ready0", 32'(req0_ready), 32'(1));
    checkOutput("t1_ready1", 32'(req1_ready), 32'(0));
    step();
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0);
    expectWord(4'b1101, 1'b0);
    checkOutput("t1_idle_busy", 32'(busy), 32'(0));
    checkOutput("t1_idle_valid", 32'(so_valid), 32'(0));

    // Both valid: alternating grants from a freshly reset pointer
    applyReset();
    applyStimulus(1'b1, 4'b0011, 1'b1, 4'b1010);
    checkOutput("t2_grant_a", 32'({req1_ready, req0_ready}), 32'(2'b01));
    step();
    expectWord(4'b0011, 1'b0);
    checkOutput("t2_grant_b", 32'({req1_ready, req0_ready}), 32'(2'b10));
    step();
    expectWord(4'b1010, 1'b1);
    checkOutput("t2_grant_c", 32'({req1_ready, req0_ready}), 32'(2'b01));
    step();
    expectWord(4'b0011, 1'b0);
    checkOutput("t2_grant_d", 32'({req1_ready, req0_ready}), 32'(2'b10));
    step();
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0);
    expectWord(4'b1010, 1'b1);

    // Lone req1 back-to-back
    applyReset();
    applyStimulus(1'b0, 4'b0, 1'b1, 4'b0110);
    n = 0;
    viol = 0;
    for (int c = 0; c < 16; c++) begin
      if (req1_ready && n < 8) begin
        hs[n] = c;
        n++;
      end
      if (busy && (req0_ready || req1_ready)) viol++;
      step();
    end
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0);
    repeat (5) step();
    checkOutput("t3_count", 32'(n), 32'(4));
    checkOutput("t3_first", 32'(hs[0]), 32'(0));
    checkOutput("t3_space1", 32'(hs[1] - hs[0]), 32'(5));
    checkOutput("t3_space2", 32'(hs[2] - hs[1]), 32'(5));
    checkOutput("t3_viol", 32'(viol), 32'(0));

    // WIDTH=8, GAP=2 instance
    a5 = 8'hA5;
    w_valid = 1'b1;
    w_data = a5;
    #1;
    checkOutput("t4_ready", 32'(w_ready), 32'(1));
    checkOutput("t4_ready1", 32'(w1_ready), 32'(0));
    step();
    w_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t4_so[%0d]", i), 32'(w_so), 32'(a5[i]));
      checkOutput("t4_valid", 32'(w_so_valid), 32'(1));
      checkOutput("t4_last", 32'(w_so_last), 32'(i == 7));
      checkOutput("t4_src", 32'(w_so_src), 32'(0));
      step();
    end
    w_valid = 1'b1;
    w_data = 8'h3C;
    #1;
    for (int g = 0; g < 2; g++) begin
      checkOutput("t4_gap_busy", 32'(w_busy), 32'(1));
      checkOutput("t4_gap_valid", 32'(w_so_valid), 32'(0));
      checkOutput("t4_gap_so", 32'(w_so), 32'(0));
      checkOutput("t4_gap_ready", 32'(w_ready), 32'(0));
      step();
    end
    checkOutput("t4_idle_busy", 32'(w_busy), 32'(0));
    checkOutput("t4_idle_ready", 32'(w_ready), 32'(1));
    w_valid = 1'b0;

    // Async reset mid-word
    applyReset();
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0);
    step();
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0);
    checkOutput("t5_bit0", 32'(so), 32'(1));
    step();
    checkOutput("t5_bit1", 32'(so), 32'(1));
    step();
    rst = 1'b1;
    #1;
    checkOutput("t5_async", 32'({so, so_valid, busy}), 32'(0));
    step();
    rst = 1'b0;
    #1;
    checkOutput("t5_idle", 32'(busy), 32'(0));
    checkOutput("t5_w8_idle", 32'(w_busy), 32'(0));
    applyStimulus(1'b1, 4'b1001, 1'b1, 4'b0110);
    checkOutput("t5_ptr_reset", 32'({req1_ready, req0_ready}), 32'(2'b01));
    step();
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0);
    expectWord(4'b1001, 1'b0);

    // req0 arrives while a req1 word finishes
    applyReset();
    applyStimulus(1'b0, 4'b0, 1'b1, 4'b0100);
    step();
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0);
    for (int i = 0; i < 4; i++) begin
      if (i >= 2) applyStimulus(1'b1, 4'b1110, 1'b0, 4'b0);
      checkOutput("t6_no_ready", 32'(req0_ready), 32'(0));
      checkOutput("t6_src", 32'(so_src), 32'(1));
      step();
    end
    checkOutput("t6_ready_idle", 32'(req0_ready), 32'(1));
    step();
    applyStimulus(1'b0, 4'b0, 1'b0, 4'b0);
    expectWord(4'b1110, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
